nand3_structural_unit: RTL and testbench
========================================

Name: nand3_structural_unit

Overview:
- 3-input NAND built strictly from 2-input NAND primitive cells.
- Provides a combinational output `y_nand` plus a registered copy.
- A self-check compares the structural network against a behavioural reference and raises a sticky mismatch flag.
- A saturating counter tallies clock cycles in which the registered output is low.
- Used as a gate-level building block and NAND-universality demonstrator in the logic experiments area.

Parameters:
- CNT_W, 8, width of the low-output cycle counter (saturating).

Ports:
- clk  input  1  rising-edge clock for all registered state
- rst  input  1  synchronous, active-high reset
- A  input  1  data input A
- B  input  1  data input B
- C  input  1  data input C
- y_nand  output  1  combinational result, equals ~(A & B & C)
- y_nand_q  output  1  y_nand registered on the rising edge of clk
- mismatch  output  1  sticky flag: structural result differed from the reference
- low_count  output  CNT_W  number of cycles in which y_nand_q was 0, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Structural network: exactly three 2-input NAND cells, instantiated explicitly; no behavioural AND/OR/NOT on this path.
  - n1 = NAND(A, B)
  - n2 = NAND(n1, n1), which yields A & B
  - y_nand = NAND(n2, C)
- y_nand is purely combinational:
  - Independent of clk and rst.
  - Valid after gate propagation, with no clock required.
- Truth table (ABC to y_nand): 000 to 1, 001 to 1, 010 to 1, 011 to 1, 100 to 1, 101 to 1, 110 to 1, 111 to 0.
- Reference path: ref = ~(A & B & C), written behaviourally and kept separate from the structural cells.
- On each rising edge of clk with rst = 1:
  - y_nand_q <= 1 (the NAND idle value)
  - mismatch <= 0
  - low_count <= 0
- On each rising edge of clk with rst = 0:
  - y_nand_q <= y_nand (latency of 1 cycle).
  - mismatch <= mismatch | (y_nand != ref). Once set, it stays set until rst.
  - If y_nand_q == 0 and low_count != all-ones, low_count increments by 1.
  - The increment uses the current (pre-edge) y_nand_q, so the count lags the input by 2 edges.
  - At all-ones, low_count holds (saturates, no wrap).
- Reset mid-operation: rst has priority over every update in the same edge.
  - The combinational y_nand continues to track the inputs during reset.
- X or Z on any input: no requirement beyond standard simulator propagation.
  - mismatch is only required to be reliable for known 0/1 inputs.
- No handshake: inputs may change at any time.
  - Registered outputs reflect only the values sampled at the clock edge.

Test Plan:
- Combinational sweep, no clock: drive ABC through 000..111, holding each value for 10 time units -> y_nand is 1 for 000..110 and 0 for 111.
- Registered latency: rst = 1 for 2 cycles, then rst = 0 with ABC = 111 at edge k -> y_nand_q = 1 before edge k and 0 after edge k. Change ABC to 011 -> y_nand_q returns to 1 one edge later.
- Counter and saturation: CNT_W = 2, hold ABC = 111 for 6 cycles after reset -> low_count goes 0, 1, 2, 3, 3 (saturates at 3, no wrap).
- Reset mid-run: after low_count = 2 with ABC = 111, assert rst for 1 edge -> on that edge y_nand_q = 1, low_count = 0, mismatch = 0, while y_nand stays 0.
- Self-check: run all 8 input combinations over 8 clocked cycles -> mismatch stays 0. Force the n2 net to 0 with ABC = 111 -> mismatch = 1 at the next edge, and it stays 1 after the force is released until rst.
- Structural audit: inspect the netlist/elaboration -> exactly three 2-input NAND cells on the y_nand path and no other logic primitives.

Source files
------------

// File: rtl/nand3_structural_unit.sv
// 3-input NAND built only from 2-input NAND cells. It also provides a registered
// copy of the output, a sticky self-check against a behavioural reference, and a
// saturating count of the cycles in which the registered output was low.

module Nand2Cell (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = ~(a_i & b_i);

endmodule

module nand3_structural_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             y_nand,
  output logic             y_nand_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] low_count
);

  logic n1;
  logic n2;
  logic refNand;

  logic             yNand_q,    yNand_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] lowCount_q, lowCount_d;

  // The second cell, with its inputs tied together, inverts n1 back to A & B.
  Nand2Cell u_n1 (.a_i(A),  .b_i(B),  .y_o(n1));
  Nand2Cell u_n2 (.a_i(n1), .b_i(n1), .y_o(n2));
  Nand2Cell u_n3 (.a_i(n2), .b_i(C),  .y_o(y_nand));

  assign refNand = ~(A & B & C);

  // The counter uses the pre-edge registered value, so it lags the inputs by two edges.
  always_comb begin
    yNand_d    = y_nand;
    mismatch_d = mismatch_q | (y_nand != refNand);
    lowCount_d = lowCount_q;
    if (!yNand_q && (lowCount_q != {CNT_W{1'b1}})) begin
      lowCount_d = lowCount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      yNand_q    <= 1'b1;
      mismatch_q <= 1'b0;
      lowCount_q <= '0;
    end else begin
      yNand_q    <= yNand_d;
      mismatch_q <= mismatch_d;
      lowCount_q <= lowCount_d;
    end
  end

  assign y_nand_q  = yNand_q;
  assign mismatch  = mismatch_q;
  assign low_count = lowCount_q;

endmodule

// File: tb/tb_nand3_structural_unit.sv
// Scoreboard bench for nand3_structural_unit, built with a 2-bit counter so that saturation is reachable.
// Stimulus pushes the hand-computed expectations, and a monitor pops and compares them on the falling edge.

module tb_nand3_structural_unit;

  typedef struct {
    string      name;
    logic       expY;
    logic       expQ;
    logic       expMis;
    logic [1:0] expCnt;
  } ExpItem;

  logic       clk = 1'b0;
  logic       rst;
  logic       A, B, C;
  logic       y_nand, y_nand_q, mismatch;
  logic [1:0] low_count;

  ExpItem sb[$];
  int     vectors = 0;
  int     miscompares = 0;

  nand3_structural_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
    .y_nand(y_nand), .y_nand_q(y_nand_q), .mismatch(mismatch), .low_count(low_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one vector, clock it in, and queue the response expected after that edge.
  task automatic applyStimulus(input logic [2:0] abc, input logic r, input logic frc,
                               input logic expY, input logic expQ, input logic expMis,
                               input logic [1:0] expCnt, input string name);
    ExpItem it;
    @(negedge clk);
    #1;
    {A, B, C} = abc;
    rst = r;
    if (frc) force dut.n2 = 1'b0;
    else     release dut.n2;
    @(posedge clk);
    it.name = name; it.expY = expY; it.expQ = expQ; it.expMis = expMis; it.expCnt = expCnt;
    sb.push_back(it);
  endtask

  initial begin : monitor
    ExpItem it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checkOutput({it.name, ".y_nand"},    {7'd0, y_nand},    {7'd0, it.expY});
        checkOutput({it.name, ".y_nand_q"},  {7'd0, y_nand_q},  {7'd0, it.expQ});
        checkOutput({it.name, ".mismatch"},  {7'd0, mismatch},  {7'd0, it.expMis});
        checkOutput({it.name, ".low_count"}, {6'd0, low_count}, {6'd0, it.expCnt});
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [3:0] v;
    rst = 1'b1;
    {A, B, C} = 3'b000;

    // Combinational sweep with reset held.
    for (int i = 0; i < 8; i++) begin
      v = 4'(i);
      {A, B, C} = v[2:0];
      #10;
      checkOutput($sformatf("comb_%0d", i), {7'd0, y_nand}, {7'd0, (i != 7)});
    end

    //            abc     rst  frc  y     q     mis   cnt
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "reset0");
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "reset1");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "lat_k");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "cnt1");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, "cnt2");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, "cnt3");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, "sat0");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, "sat1");
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, "back_hi");
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, "hold_hi");

    // Reset in the middle of a run, with low_count at 2 and ABC = 111.
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "rst_a");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "run0");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "run1");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, "run2");
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "rst_mid");

    // Self-check across all eight inputs: mismatch must stay low.
    for (int i = 0; i < 8; i++) begin
      v = 4'(i);
      applyStimulus(v[2:0], 1'b0, 1'b0, (i != 7), (i != 7), 1'b0, 2'd0, $sformatf("self_%0d", i));
    end
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, "self_after");

    // A fault forced on n2 makes the structural result differ from the reference, and the flag stays set.
    applyStimulus(3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, "force_n2");
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, "sticky0");
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, "sticky1");
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "clear");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
